fetch_pc_unit: RTL and testbench

FETCH_PC_UNIT -- requirements
Module: fetch_pc_unit

---
 rtl/fetch_pc_unit_pkg.sv | 23 ++
 rtl/pc_target_mux.sv | 41 ++++
 rtl/fetch_pc_unit.sv | 113 +++++++++++
 tb/tb_fetch_pc_unit.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pc_unit_pkg.sv
// Shared fetch/branch-control definitions: PC select encodings, vectors and FSM states.
// MISALIGN_TRAP_EN (consumed by pc_target_mux) enables the misaligned-redirect trap.
package fetch_pc_unit_pkg;

  localparam logic [1:0] PC_SEL_SEQ  = 2'b00;
  localparam logic [1:0] PC_SEL_JALR = 2'b01;
  localparam logic [1:0] PC_SEL_BR   = 2'b10;

  localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] TRAP_VECTOR  = 32'h0000_0100;

  typedef enum logic [1:0] {
    StIdle    = 2'b00,
    StFetch   = 2'b01,
    StDiscard = 2'b10,
    StHold    = 2'b11
  } fetch_state_e;

  function automatic logic [31:0] seq_pc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/pc_target_mux.sv
// Combinational redirect detection, target select and alignment for the fetch unit.
// With MISALIGN_TRAP_EN a target with bit 1 set is replaced by TRAP_VECTOR and flagged.
module pc_target_mux
  import fetch_pc_unit_pkg::*;
(
  input  logic        branch_valid,
  input  logic [1:0]  pc_selection,
  input  logic [31:0] branch_target,
  input  logic [31:0] alu_result,
  output logic        redirect,
  output logic [31:0] target,
  output logic        misaligned
);

  logic [31:0] raw_target;

  always_comb begin
    raw_target = branch_target;
    redirect   = 1'b0;
    case (pc_selection)
      PC_SEL_JALR: begin
        raw_target = alu_result & 32'hFFFF_FFFE;
        redirect   = branch_valid;
      end
      PC_SEL_BR: begin
        raw_target = branch_target;
        redirect   = branch_valid;
      end
      default: redirect = 1'b0;
    endcase
  end

`ifdef MISALIGN_TRAP_EN
  assign misaligned = raw_target[1];
  assign target     = raw_target[1] ? TRAP_VECTOR : (raw_target & 32'hFFFF_FFFE);
`else
  assign misaligned = 1'b0;
  assign target     = raw_target & 32'hFFFF_FFFC;
`endif

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch PC unit: PC register, single-entry instruction buffer and the fetch FSM.
// Optional misaligned-target trap is selected by MISALIGN_TRAP_EN (see pc_target_mux).
module fetch_pc_unit
  import fetch_pc_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  pc_selection,
  input  logic        branch_valid,
  input  logic [31:0] branch_target,
  input  logic [31:0] alu_result,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst_out,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  output logic        flush,
  output logic        misalign_trap
);

  fetch_state_e state_q;
  logic [31:0]  pc_q;
  logic         redirect;
  logic [31:0]  target;
  logic         target_misaligned;
  logic         buf_free;

  pc_target_mux u_pc_target_mux (
    .branch_valid  (branch_valid),
    .pc_selection  (pc_selection),
    .branch_target (branch_target),
    .alu_result    (alu_result),
    .redirect      (redirect),
    .target        (target),
    .misaligned    (target_misaligned)
  );

  assign buf_free = ~inst_valid | inst_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      pc_q          <= RESET_VECTOR;
      imem_req      <= 1'b0;
      imem_addr     <= RESET_VECTOR;
      inst_valid    <= 1'b0;
      inst_out      <= 32'h0;
      inst_pc       <= 32'h0;
      flush         <= 1'b0;
      misalign_trap <= 1'b0;
    end else begin
      flush         <= 1'b0;
      misalign_trap <= 1'b0;
      if (inst_valid && inst_ready) inst_valid <= 1'b0;

      if (redirect) begin
        pc_q          <= target;
        inst_valid    <= 1'b0;
        flush         <= 1'b1;
        misalign_trap <= target_misaligned;
        // An unacknowledged request must complete at its original address first.
        if ((state_q == StFetch || state_q == StDiscard) && !imem_ack) begin
          state_q <= StDiscard;
        end else begin
          state_q   <= StFetch;
          imem_req  <= 1'b1;
          imem_addr <= target;
        end
      end else begin
        unique case (state_q)
          StIdle: begin
            state_q   <= StFetch;
            imem_req  <= 1'b1;
            imem_addr <= pc_q;
          end
          StFetch: begin
            if (imem_ack) begin
              if (buf_free) begin
                inst_out   <= imem_rdata;
                inst_pc    <= pc_q;
                inst_valid <= 1'b1;
                pc_q       <= seq_pc(pc_q);
                imem_addr  <= seq_pc(pc_q);
              end else begin
                // Buffer stalled: drop this word and refetch the same PC once drained.
                state_q  <= StHold;
                imem_req <= 1'b0;
              end
            end
          end
          StDiscard: begin
            if (imem_ack) begin
              state_q   <= StFetch;
              imem_addr <= pc_q;
            end
          end
          StHold: begin
            if (buf_free) begin
              state_q   <= StFetch;
              imem_req  <= 1'b1;
              imem_addr <= pc_q;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit with a program-order scoreboard on the decode interface.
module tb_fetch_pc_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  pc_selection;
  logic        branch_valid;
  logic [31:0] branch_target;
  logic [31:0] alu_result;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst_out;
  logic [31:0] inst_pc;
  logic        inst_ready;
  logic        flush;
  logic        misalign_trap;

  int          tests = 0;
  int          fails = 0;
  int          lat = 0;
  int          cnt = 0;
  logic        force_ack = 1'b0;
  int          flush_cnt = 0;
  logic [31:0] exp_q[$];

  fetch_pc_unit dut (
    .clk           (clk),
    .rst           (rst),
    .pc_selection  (pc_selection),
    .branch_valid  (branch_valid),
    .branch_target (branch_target),
    .alu_result    (alu_result),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .inst_valid    (inst_valid),
    .inst_out      (inst_out),
    .inst_pc       (inst_pc),
    .inst_ready    (inst_ready),
    .flush         (flush),
    .misalign_trap (misalign_trap)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_seq(input logic [31:0] start);
    exp_q.delete();
    for (int i = 0; i < 64; i++) exp_q.push_back(start + 32'(4 * i));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic redirect_to(input logic [1:0] sel, input logic [31:0] bt, input logic [31:0] alu);
    branch_valid  = 1'b1;
    pc_selection  = sel;
    branch_target = bt;
    alu_result    = alu;
  endtask

  // Memory responder: acks after 'lat' wait cycles, data is a function of the address.
  initial begin
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    forever begin
      @(posedge clk);
      #2;
      imem_ack = 1'b0;
      if (rst) begin
        cnt = 0;
      end else if (force_ack) begin
        imem_ack   = 1'b1;
        imem_rdata = mem(imem_addr);
      end else if (imem_req) begin
        if (cnt >= lat) begin
          imem_ack   = 1'b1;
          imem_rdata = mem(imem_addr);
          cnt        = 0;
        end else begin
          cnt++;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // Decode-side monitor: every accepted instruction must be the next one in program order.
  always @(negedge clk) begin
    if (!rst && flush) flush_cnt++;
    if (!rst && inst_valid && inst_ready &&
        !(branch_valid && (pc_selection == 2'b01 || pc_selection == 2'b10))) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_inst", inst_pc, 32'hDEAD_BEEF);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        check("sb_inst_pc", inst_pc, e);
        check("sb_inst_out", inst_out, mem(e));
      end
    end
  end

  initial begin
    int  flush_base;
    bit  seen;
    rst           = 1'b1;
    inst_ready    = 1'b1;
    branch_valid  = 1'b0;
    pc_selection  = 2'b00;
    branch_target = 32'h0;
    alu_result    = 32'h0;
    repeat (3) step();

    check("rst_imem_req", 32'(imem_req), 32'd0);
    check("rst_imem_addr", imem_addr, 32'h0);
    check("rst_inst_valid", 32'(inst_valid), 32'd0);
    check("rst_inst_out", inst_out, 32'h0);
    check("rst_inst_pc", inst_pc, 32'h0);
    check("rst_flush", 32'(flush), 32'd0);
    check("rst_misalign", 32'(misalign_trap), 32'd0);

    // Sequential streaming with same-cycle ack.
    rst = 1'b0;
    push_seq(32'h0);
    step();
    check("first_req", 32'(imem_req), 32'd1);
    check("first_addr", imem_addr, 32'h0);
    step(); check("seq_pc0", inst_pc, 32'h0);
    step(); check("seq_pc4", inst_pc, 32'h4);
    step(); check("seq_pc8", inst_pc, 32'h8);

    // Decode stall for three cycles.
    step(); check("stall_pc_c", inst_pc, 32'hC);
    inst_ready = 1'b0;
    repeat (2) begin
      step();
      check("stall_req_low", 32'(imem_req), 32'd0);
      check("stall_pc_hold", inst_pc, 32'hC);
      check("stall_out_hold", inst_out, mem(32'hC));
      check("stall_valid_hold", 32'(inst_valid), 32'd1);
    end
    step();
    inst_ready = 1'b1;
    check("stall_pc_last", inst_pc, 32'hC);
    step();
    check("resume_req", 32'(imem_req), 32'd1);
    check("resume_addr", imem_addr, 32'h10);
    step();
    check("resume_pc", inst_pc, 32'h10);

    // Branch redirect while the memory is two cycles late.
    lat = 2;
    step();
    redirect_to(2'b10, 32'h40, 32'h0);
    push_seq(32'h40);
    flush_base = flush_cnt;
    step();
    branch_valid = 1'b0;
    check("br_flush", 32'(flush), 32'd1);
    check("br_discard_req", 32'(imem_req), 32'd1);
    check("br_discard_addr", imem_addr, 32'h14);
    step();
    check("br_flush_clear", 32'(flush), 32'd0);
    check("br_target_addr", imem_addr, 32'h40);
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      step();
      if (inst_valid) seen = 1'b1;
    end
    check("br_valid_seen", 32'(seen), 32'd1);
    check("br_first_pc", inst_pc, 32'h40);
    check("br_flush_once", 32'(flush_cnt - flush_base), 32'd1);
    lat = 0;
    repeat (3) step();

    // JALR clears bit 0; select 11 behaves as sequential.
    redirect_to(2'b01, 32'h0000_0200, 32'h81);
    push_seq(32'h80);
    step();
    branch_valid = 1'b0;
    check("jalr_addr", imem_addr, 32'h80);
    check("jalr_flush", 32'(flush), 32'd1);
    check("jalr_no_trap", 32'(misalign_trap), 32'd0);
    step();
    step();
    redirect_to(2'b11, 32'h200, 32'h300);
    check("sel11_addr_before", imem_addr, 32'h88);
    step();
    branch_valid = 1'b0;
    check("sel11_addr_seq", imem_addr, 32'h8C);
    check("sel11_no_flush", 32'(flush), 32'd0);

    // Target with bit 1 set.
    step();
    redirect_to(2'b10, 32'h42, 32'h0);
`ifdef MISALIGN_TRAP_EN
    push_seq(32'h100);
`else
    push_seq(32'h40);
`endif
    step();
    branch_valid = 1'b0;
    check("mis_flush", 32'(flush), 32'd1);
`ifdef MISALIGN_TRAP_EN
    check("mis_trap", 32'(misalign_trap), 32'd1);
    check("mis_addr", imem_addr, 32'h100);
`else
    check("mis_trap", 32'(misalign_trap), 32'd0);
    check("mis_addr", imem_addr, 32'h40);
`endif
    step();
    check("mis_trap_pulse", 32'(misalign_trap), 32'd0);

    // PC wrap at the top of the address space.
    step();
    redirect_to(2'b10, 32'hFFFF_FFFC, 32'h0);
    push_seq(32'hFFFF_FFFC);
    step();
    branch_valid = 1'b0;
    check("wrap_addr_top", imem_addr, 32'hFFFF_FFFC);
    step();
    check("wrap_addr_zero", imem_addr, 32'h0);
    check("wrap_inst_pc_top", inst_pc, 32'hFFFF_FFFC);
    step();
    check("wrap_inst_pc_zero", inst_pc, 32'h0);

    // Redirect twice while a slow request is pending, then reset in DISCARD.
    step();
    lat = 3;
    redirect_to(2'b10, 32'h60, 32'h0);
    push_seq(32'h60);
    step();
    redirect_to(2'b10, 32'h70, 32'h0);
    push_seq(32'h70);
    check("disc_flush1", 32'(flush), 32'd1);
    check("disc_req_held", 32'(imem_req), 32'd1);
    check("disc_addr_held", imem_addr, 32'h8);
    step();
    branch_valid = 1'b0;
    check("disc_flush2", 32'(flush), 32'd1);
    check("disc_addr_held2", imem_addr, 32'h8);
    rst = 1'b1;
    step();
    check("rst2_req", 32'(imem_req), 32'd0);
    check("rst2_addr", imem_addr, 32'h0);
    check("rst2_valid", 32'(inst_valid), 32'd0);
    check("rst2_out", inst_out, 32'h0);
    check("rst2_flush", 32'(flush), 32'd0);
    rst       = 1'b0;
    lat       = 0;
    force_ack = 1'b1;
    push_seq(32'h0);
    step();
    force_ack = 1'b0;
    check("late_ack_req", 32'(imem_req), 32'd1);
    check("late_ack_addr", imem_addr, 32'h0);
    check("late_ack_valid", 32'(inst_valid), 32'd0);
    step();
    check("post_rst_pc", inst_pc, 32'h0);
    check("post_rst_out", inst_out, mem(32'h0));
    repeat (2) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
